regfile_dump: RTL and testbench

- Debug read-out sequencer that acts as the reading end of the register file's combinational read port.
- On a start pulse it walks a contiguous range of register numbers, one read per register.
- It samples each read value and streams it out as (index, data) beats over a valid/ready handshake toward the debug/display path.
- It sits beside the ID-stage read ports and drives a dedicated third read address into the register file.

---
 rtl/regfile_dump.sv | 103 ++++++++++
 tb/tb_regfile_dump.sv | 311 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/regfile_dump.sv
// regfile_dump: debug read-out sequencer that walks a register range
// through a spare register-file read port and streams (index, data) beats.
module regfile_dump #(
  parameter int DATA_W = 32,
  parameter int ADDR_W = 5
) (
  input  logic              clk,
  input  logic              clrn,
  input  logic              start,
  input  logic              abort,
  input  logic [ADDR_W-1:0] first_reg,
  input  logic [ADDR_W-1:0] last_reg,
  output logic [ADDR_W-1:0] rf_raddr,
  input  logic [DATA_W-1:0] rf_rdata,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [DATA_W-1:0] out_data,
  output logic [ADDR_W-1:0] out_index,
  output logic              out_last,
  output logic              busy,
  output logic              done
);

  typedef enum logic [1:0] {
    IDLE,
    READ,
    SEND,
    DONE
  } state_t;

  state_t            state;
  state_t            state_nxt;
  logic [ADDR_W-1:0] idx;
  logic [ADDR_W-1:0] end_reg;
  logic              hs;
  logic              kill;

  // A beat leaves only when the sink takes it.
  assign hs   = out_valid & out_ready;
  // Abort is honoured in every non-idle state.
  assign kill = abort & (state != IDLE);

  // State register.
  always_ff @(posedge clk) begin
    if (clrn) state <= IDLE;
    else      state <= state_nxt;
  end

  // Next-state logic; abort beats a same-cycle handshake.
  always_comb begin
    state_nxt = state;
    unique case (state)
      IDLE:    if (start) state_nxt = READ;
      READ:    state_nxt = SEND;
      SEND: begin
        if (hs) state_nxt = out_last ? DONE : READ;
      end
      DONE:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
    if (kill) state_nxt = IDLE;
  end

  // Outputs decoded from state; the read address is always the walk pointer.
  always_comb begin
    out_valid = (state == SEND);
    busy      = (state != IDLE);
    done      = (state == DONE);
    rf_raddr  = idx;
  end

  // Walk pointer, range end and captured beat.
  always_ff @(posedge clk) begin
    if (clrn) begin
      idx       <= '0;
      end_reg   <= '0;
      out_data  <= '0;
      out_index <= '0;
      out_last  <= 1'b0;
    end else if (kill) begin
      out_last  <= 1'b0;
    end else begin
      unique case (state)
        IDLE: begin
          if (start) begin
            idx     <= first_reg;
            end_reg <= last_reg;
          end
        end
        READ: begin
          out_data  <= rf_rdata;
          out_index <= idx;
          out_last  <= (idx == end_reg);
        end
        SEND: begin
          if (hs && !out_last) idx <= idx + 1'b1;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_regfile_dump.sv
// tb_regfile_dump: directed bench with a range-walk scoreboard model
// and a small register file feeding the dump port.
module tb_regfile_dump;

  logic        clk = 1'b0;
  logic        clrn = 1'b1;
  logic        start = 1'b0;
  logic        abort = 1'b0;
  logic [4:0]  first_reg = '0;
  logic [4:0]  last_reg = '0;
  logic [4:0]  rf_raddr;
  logic [31:0] rf_rdata;
  logic        out_valid;
  logic        out_ready = 1'b1;
  logic [31:0] out_data;
  logic [4:0]  out_index;
  logic        out_last;
  logic        busy;
  logic        done;

  logic        we = 1'b0;
  logic [4:0]  waddr = '0;
  logic [31:0] wdata = '0;
  logic [31:0] rf [32];

  int checks = 0;
  int errors = 0;
  int cyc = 0;

  regfile_dump #(.DATA_W(32), .ADDR_W(5)) dut (
    .clk(clk), .clrn(clrn), .start(start), .abort(abort),
    .first_reg(first_reg), .last_reg(last_reg),
    .rf_raddr(rf_raddr), .rf_rdata(rf_rdata),
    .out_valid(out_valid), .out_ready(out_ready),
    .out_data(out_data), .out_index(out_index),
    .out_last(out_last), .busy(busy), .done(done)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // register file: write lands at the edge, read is combinational
  always @(posedge clk) if (we && waddr != 5'd0) rf[waddr] <= wdata;
  assign rf_rdata = (rf_raddr == 5'd0) ? 32'h0 : rf[rf_raddr];

  task automatic chk(input string nm, input logic [63:0] act,
                     input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h, need %0h", nm, act, exp);
    end
  endtask

  typedef struct packed {
    logic [4:0]  idx;
    logic [31:0] data;
    logic        last;
  } beat_t;

  typedef struct {
    logic [4:0]  idx;
    logic [31:0] data;
    logic        last;
    int          at;
  } log_t;

  beat_t q[$];
  log_t  log_q[$];
  int    done_at[$];
  int    stalls = 0;
  bit    armed = 0;
  bit    rd_pend = 0;
  bit    exp_done = 0;
  bit    hold = 0;
  logic [31:0] h_data;
  logic [4:0]  h_idx;
  logic        h_last;

  // scoreboard: expected beats are the register contents over the
  // wrapped range as they stood when the dump was accepted
  always @(negedge clk) begin
    logic [4:0] d;
    logic [4:0] ix;
    if (armed) begin
      chk("done", done, exp_done);
      chk("busy", busy, (q.size() != 0) || exp_done);
      chk("valid", out_valid, (q.size() != 0) && !rd_pend);
      if (q.size() != 0 && rd_pend)
        chk("raddr", rf_raddr, q[0].idx);
      if (q.size() != 0 && !rd_pend) begin
        chk("index", out_index, q[0].idx);
        chk("data", out_data, q[0].data);
        chk("last", out_last, q[0].last);
      end
      if (hold) begin
        chk("hold_valid", out_valid, 1'b1);
        chk("hold_data", out_data, h_data);
        chk("hold_index", out_index, h_idx);
        chk("hold_last", out_last, h_last);
      end
      if (out_valid && out_ready && !abort && !clrn)
        log_q.push_back('{out_index, out_data, out_last, cyc + 1});
      if (done) done_at.push_back(cyc + 1);
      if (out_valid && !out_ready && out_index == 5'd2) stalls++;
    end
    hold   = out_valid && !out_ready && !abort && !clrn;
    h_data = out_data;
    h_idx  = out_index;
    h_last = out_last;
    if (clrn) begin
      q.delete();
      rd_pend  = 0;
      exp_done = 0;
      armed    = 1;
    end else if ((q.size() != 0 || exp_done) && abort) begin
      q.delete();
      rd_pend  = 0;
      exp_done = 0;
    end else if (exp_done) begin
      exp_done = 0;
    end else if (q.size() == 0) begin
      if (start) begin
        d = last_reg - first_reg;
        for (int k = 0; k <= int'(d); k++) begin
          ix = first_reg + 5'(k);
          q.push_back('{ix, (ix == 5'd0) ? 32'h0 : rf[ix], k == int'(d)});
        end
        rd_pend = 1;
      end
    end else if (rd_pend) begin
      rd_pend = 0;
    end else if (out_ready) begin
      if (q[0].last) exp_done = 1;
      else           rd_pend = 1;
      void'(q.pop_front());
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk_beat(input int i, input logic [4:0] ix,
                          input logic [31:0] d, input logic l);
    if (i >= log_q.size()) begin
      checks++;
      errors++;
      $display("FAIL beat%0d: got %0d beats, need more than %0d",
               i, log_q.size(), i);
    end else begin
      chk($sformatf("beat%0d_idx", i), log_q[i].idx, ix);
      chk($sformatf("beat%0d_data", i), log_q[i].data, d);
      chk($sformatf("beat%0d_last", i), log_q[i].last, l);
    end
  endtask

  // mode 0 plain, 1 stall beat r2, 2 same-edge write r2,
  // 3 abort on 2nd beat, 4 reset+start on 2nd beat
  task automatic run(input logic [4:0] f, input logic [4:0] l,
                     input int mode, output int n0, output int idle_at);
    bit fired = 0;
    bit ended = 0;
    int sd = 0;
    log_q.delete();
    done_at.delete();
    stalls = 0;
    idle_at = -1;
    first_reg = f;
    last_reg = l;
    start = 1'b1;
    tick();
    n0 = cyc;
    start = 1'b0;
    for (int k = 0; k < 80; k++) begin
      tick();
      out_ready = 1'b1;
      we = 1'b0;
      abort = 1'b0;
      clrn = 1'b0;
      start = 1'b0;
      if (!busy) begin
        idle_at = cyc + 1;
        ended = 1;
        break;
      end
      if (mode == 1 && out_valid && out_index == 5'd2 && sd < 5) begin
        out_ready = 1'b0;
        sd++;
      end
      if (mode == 2 && !out_valid && !done && rf_raddr == 5'd2) begin
        we = 1'b1;
        waddr = 5'd2;
        wdata = 32'hDEAD;
      end
      if (mode >= 3 && !fired && out_valid && out_index == f + 5'd1) begin
        fired = 1;
        if (mode == 3) begin
          abort = 1'b1;
        end else begin
          clrn = 1'b1;
          start = 1'b1;
          first_reg = 5'd9;
          last_reg = 5'd12;
        end
      end
    end
    if (!ended) begin
      checks++;
      errors++;
      $display("FAIL timeout: dump %0d..%0d never went idle", f, l);
    end
  endtask

  task automatic chk_reset(input string tag);
    chk({tag, "_valid"}, out_valid, 1'b0);
    chk({tag, "_data"}, out_data, 32'h0);
    chk({tag, "_index"}, out_index, 5'd0);
    chk({tag, "_last"}, out_last, 1'b0);
    chk({tag, "_raddr"}, rf_raddr, 5'd0);
    chk({tag, "_busy"}, busy, 1'b0);
    chk({tag, "_done"}, done, 1'b0);
  endtask

  initial begin
    #400000;
    $display("FAIL watchdog: bench did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    int n;
    int ia;
    // fill r1..r31 with i*0x11 while held in reset
    for (int i = 1; i < 32; i++) begin
      we = 1'b1;
      waddr = 5'(i);
      wdata = 32'(i * 17);
      tick();
    end
    we = 1'b0;
    tick();
    chk_reset("rst");
    clrn = 1'b0;
    tick();

    // basic 1..3 with exact timing
    run(5'd1, 5'd3, 0, n, ia);
    chk("t1_beats", log_q.size(), 3);
    chk_beat(0, 5'd1, 32'h11, 1'b0);
    chk_beat(1, 5'd2, 32'h22, 1'b0);
    chk_beat(2, 5'd3, 32'h33, 1'b1);
    if (log_q.size() == 3)
      for (int i = 0; i < 3; i++)
        chk($sformatf("t1_at%0d", i), log_q[i].at, n + 2 + 2 * i);
    chk("t1_ndone", done_at.size(), 1);
    if (done_at.size() == 1) chk("t1_done_at", done_at[0], n + 7);
    chk("t1_idle_at", ia, n + 8);

    // wrapped range 30..1
    run(5'd30, 5'd1, 0, n, ia);
    chk("t2_beats", log_q.size(), 4);
    chk_beat(0, 5'd30, 32'h1FE, 1'b0);
    chk_beat(1, 5'd31, 32'h20F, 1'b0);
    chk_beat(2, 5'd0, 32'h0, 1'b0);
    chk_beat(3, 5'd1, 32'h11, 1'b1);

    // backpressure on beat 2
    run(5'd1, 5'd3, 1, n, ia);
    chk("t3_stalls", stalls, 5);
    chk("t3_beats", log_q.size(), 3);
    chk_beat(0, 5'd1, 32'h11, 1'b0);
    chk_beat(1, 5'd2, 32'h22, 1'b0);
    chk_beat(2, 5'd3, 32'h33, 1'b1);

    // same-edge write is not visible to the READ in flight
    run(5'd1, 5'd3, 2, n, ia);
    chk_beat(1, 5'd2, 32'h22, 1'b0);
    run(5'd2, 5'd2, 0, n, ia);
    chk("t4_beats", log_q.size(), 1);
    chk_beat(0, 5'd2, 32'hDEAD, 1'b1);

    // abort during 2nd beat of 5..8
    run(5'd5, 5'd8, 3, n, ia);
    chk("t5_valid", out_valid, 1'b0);
    chk("t5_beats", log_q.size(), 1);
    chk("t5_ndone", done_at.size(), 0);
    run(5'd10, 5'd12, 0, n, ia);
    chk_beat(0, 5'd10, 32'hAA, 1'b0);
    chk_beat(1, 5'd11, 32'hBB, 1'b0);
    chk_beat(2, 5'd12, 32'hCC, 1'b1);
    chk("t5b_ndone", done_at.size(), 1);

    // reset with start mid-dump
    run(5'd1, 5'd4, 4, n, ia);
    chk_reset("t6");
    chk("t6_ndone", done_at.size(), 0);
    tick();
    chk("t6_idle", busy, 1'b0);
    run(5'd3, 5'd3, 0, n, ia);
    chk("t6_beats", log_q.size(), 1);
    chk_beat(0, 5'd3, 32'h33, 1'b1);

    tick();
    tick();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
